// File: rtl/conv_ctrl_64_33_2.sv
// Control FSM for the 1-D convolution datapath (N=64, M=33, P=2, L=2).
// LOAD fills the x memory from a valid/ready stream, COMPUTE walks the M
// filter taps for one output group, DRAIN waits out the MAC pipeline, and
// OUTPUT streams the P lane results out one at a time.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. s_ready_x is only ever high in LOAD. m_valid_y, once raised,
// holds with out_sel stable until m_ready_y accepts it; m_ready_y is ignored
// while m_valid_y is low.
module conv_ctrl_64_33_2 #(
   parameter int N = 64,
   parameter int M = 33,
   parameter int P = 2,
   parameter int L = 2,
   localparam int AW = $clog2(N),
   localparam int FW = $clog2(M),
   localparam int SW = (P > 1) ? $clog2(P) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s_valid_x,
   output logic          s_ready_x,
   output logic          x_wr_en,
   output logic [AW-1:0] x_addr,
   output logic [FW-1:0] f_addr,
   output logic          clr_acc,
   output logic          en_acc,
   output logic [SW-1:0] out_sel,
   output logic          m_valid_y,
   input  logic          m_ready_y,
   output logic [1:0]    fsm_state
);

   localparam int G  = (N - M + 1) / P;
   localparam int GW = (G > 1) ? $clog2(G) : 1;
   localparam int DW = (L > 1) ? $clog2(L) : 1;

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DRAIN   = 2'd2,
      S_OUTPUT  = 2'd3
   } state_t;

   state_t        state;
   logic [AW-1:0] n;
   logic [GW-1:0] g;
   logic [FW-1:0] k;
   logic [DW-1:0] d;
   logic [SW-1:0] lane;

   logic          s_ready_q;
   logic [AW-1:0] x_addr_q;
   logic [FW-1:0] f_addr_q;
   logic          clr_q;
   logic          en_q;
   logic [SW-1:0] out_sel_q;
   logic          m_valid_q;

   // Sequencer: state, counters and registered outputs all advance together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LOAD;
         n         <= '0;
         g         <= '0;
         k         <= '0;
         d         <= '0;
         lane      <= '0;
         s_ready_q <= 1'b1;
         x_addr_q  <= '0;
         f_addr_q  <= '0;
         clr_q     <= 1'b0;
         en_q      <= 1'b0;
         out_sel_q <= '0;
         m_valid_q <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               // s_ready_q is always high here, so a handshake is just s_valid_x.
               if (s_valid_x) begin
                  if (n == AW'(N - 1)) begin
                     state     <= S_COMPUTE;
                     n         <= '0;
                     g         <= '0;
                     k         <= '0;
                     s_ready_q <= 1'b0;
                     en_q      <= 1'b1;
                     clr_q     <= 1'b1;
                     x_addr_q  <= '0;
                     f_addr_q  <= '0;
                  end else begin
                     n        <= n + AW'(1);
                     x_addr_q <= n + AW'(1);
                  end
               end
            end
            S_COMPUTE: begin
               if (k == FW'(M - 1)) begin
                  state    <= S_DRAIN;
                  d        <= '0;
                  en_q     <= 1'b0;
                  clr_q    <= 1'b0;
                  x_addr_q <= '0;
                  f_addr_q <= '0;
               end else begin
                  // x_addr = g*P + k, so it steps in lockstep with the tap.
                  k        <= k + FW'(1);
                  clr_q    <= 1'b0;
                  f_addr_q <= k + FW'(1);
                  x_addr_q <= x_addr_q + AW'(1);
               end
            end
            S_DRAIN: begin
               if (d == DW'(L - 1)) begin
                  state     <= S_OUTPUT;
                  lane      <= '0;
                  m_valid_q <= 1'b1;
                  out_sel_q <= '0;
               end else begin
                  d <= d + DW'(1);
               end
            end
            S_OUTPUT: begin
               if (m_ready_y) begin
                  if (lane == SW'(P - 1)) begin
                     m_valid_q <= 1'b0;
                     out_sel_q <= '0;
                     lane      <= '0;
                     if (g == GW'(G - 1)) begin
                        state     <= S_LOAD;
                        n         <= '0;
                        g         <= '0;
                        s_ready_q <= 1'b1;
                        x_addr_q  <= '0;
                     end else begin
                        state    <= S_COMPUTE;
                        g        <= g + GW'(1);
                        k        <= '0;
                        en_q     <= 1'b1;
                        clr_q    <= 1'b1;
                        f_addr_q <= '0;
                        x_addr_q <= AW'((int'(g) + 1) * P);
                     end
                  end else begin
                     lane      <= lane + SW'(1);
                     out_sel_q <= lane + SW'(1);
                  end
               end
            end
            default: begin
               state <= S_LOAD;
            end
         endcase
      end
   end

   // While reset is asserted every control output reads as idle/zero.
   assign s_ready_x = s_ready_q & ~reset;
   assign x_wr_en   = s_valid_x & s_ready_q & ~reset;
   assign x_addr    = reset ? '0 : x_addr_q;
   assign f_addr    = reset ? '0 : f_addr_q;
   assign clr_acc   = clr_q & ~reset;
   assign en_acc    = en_q & ~reset;
   assign out_sel   = reset ? '0 : out_sel_q;
   assign m_valid_y = m_valid_q & ~reset;
   assign fsm_state = state;

endmodule

// File: tb/tb_conv_ctrl_64_33_2.sv
// Bench for conv_ctrl_64_33_2: a per-cycle vector table for one full
// always-valid/always-ready vector, directed backpressure and mid-compute
// reset sequences, and a random-handshake run with an output-order scoreboard.
module tb_conv_ctrl_64_33_2;

  localparam int N  = 64;
  localparam int M  = 33;
  localparam int P  = 2;
  localparam int L  = 2;
  localparam int G  = (N - M + 1) / P;
  localparam int NY = N - M + 1;
  localparam int RV = 40;
  localparam int W  = 8;

  logic       clk;
  logic       reset;
  logic       s_valid_x;
  logic       s_ready_x;
  logic       x_wr_en;
  logic [5:0] x_addr;
  logic [5:0] f_addr;
  logic       clr_acc;
  logic       en_acc;
  logic [0:0] out_sel;
  logic       m_valid_y;
  logic       m_ready_y;
  logic [1:0] fsm_state;

  conv_ctrl_64_33_2 dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid_x (s_valid_x),
    .s_ready_x (s_ready_x),
    .x_wr_en   (x_wr_en),
    .x_addr    (x_addr),
    .f_addr    (f_addr),
    .clr_acc   (clr_acc),
    .en_acc    (en_acc),
    .out_sel   (out_sel),
    .m_valid_y (m_valid_y),
    .m_ready_y (m_ready_y),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int in_hs  = 0;
  int out_hs = 0;
  int vec_words = 0;
  logic [5:0] grp_base = '0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard / protocol monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      vec_words = 0;
    end else begin
      check("wr_gate", x_wr_en, s_valid_x && s_ready_x);
      check("exclusive", 32'(s_ready_x) + 32'(en_acc) + 32'(m_valid_y) <= 1, 1);
      if (s_valid_x && s_ready_x) begin
        in_hs++;
        vec_words++;
        if (vec_words == N) begin
          vec_words = 0;
          for (int i = 0; i < NY; i++) exp_q.push_back(W'(i));
        end
      end
      if (clr_acc) grp_base = x_addr;
      if (m_valid_y && m_ready_y) begin
        out_hs++;
        if (exp_q.size() == 0) begin
          check("y_unexpected", 1, 0);
        end else begin
          check("y_index", 32'(grp_base) + 32'(out_sel), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  typedef struct {
    logic       sv;
    logic       mr;
    logic       rdy;
    logic       wr;
    logic       chk_xa;
    logic [5:0] xa;
    logic [5:0] fa;
    logic       clr;
    logic       en;
    logic       mv;
    logic [0:0] sel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic sv, logic rdy, logic wr, logic chk_xa, int xa,
                              int fa, logic clr, logic en, logic mv, int sel);
    vec_t v;
    v.sv = sv; v.mr = 1'b1; v.rdy = rdy; v.wr = wr; v.chk_xa = chk_xa;
    v.xa = 6'(xa); v.fa = 6'(fa); v.clr = clr; v.en = en; v.mv = mv; v.sel = 1'(sel);
    return v;
  endfunction

  initial begin
    bit found;
    // expected per-cycle schedule of one vector with valid/ready held high
    for (int i = 0; i < N; i++) vecs.push_back(mk(1, 1, 1, 1, i, 0, 0, 0, 0, 0));
    for (int gg = 0; gg < G; gg++) begin
      for (int kk = 0; kk < M; kk++)
        vecs.push_back(mk(1, 0, 0, 1, gg * P + kk, kk, kk == 0, 1, 0, 0));
      for (int dd = 0; dd < L; dd++) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int ll = 0; ll < P; ll++) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, ll));
    end
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0));

    // reset, with valid/ready high to show they are ignored
    reset = 1'b1; s_valid_x = 1'b1; m_ready_y = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_ready", s_ready_x, 0);
    check("rst_wr", x_wr_en, 0);
    check("rst_en", en_acc, 0);
    check("rst_clr", clr_acc, 0);
    check("rst_valid", m_valid_y, 0);
    check("rst_xaddr", x_addr, 0);
    check("rst_faddr", f_addr, 0);
    check("rst_sel", out_sel, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // table: full vector, 656 cycles, then LOAD again on entry 656
    for (int i = 0; i < vecs.size(); i++) begin
      s_valid_x = vecs[i].sv;
      m_ready_y = vecs[i].mr;
      @(negedge clk);
      check($sformatf("v%0d_rdy", i), s_ready_x, vecs[i].rdy);
      check($sformatf("v%0d_wr", i), x_wr_en, vecs[i].wr);
      if (vecs[i].chk_xa) check($sformatf("v%0d_xaddr", i), x_addr, vecs[i].xa);
      check($sformatf("v%0d_faddr", i), f_addr, vecs[i].fa);
      check($sformatf("v%0d_clr", i), clr_acc, vecs[i].clr);
      check($sformatf("v%0d_en", i), en_acc, vecs[i].en);
      check($sformatf("v%0d_mvalid", i), m_valid_y, vecs[i].mv);
      check($sformatf("v%0d_sel", i), out_sel, vecs[i].sel);
      @(posedge clk); #1;
    end
    check("vec_out_hs", out_hs, NY);
    check("vec_in_hs", in_hs, N);

    // backpressure in OUTPUT of group 0
    s_valid_x = 1'b1; m_ready_y = 1'b0;
    found = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (m_valid_y) begin found = 1; break; end
    end
    check("bp_wait_valid", found, 1);
    @(posedge clk); #1;
    s_valid_x = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_hold", m_valid_y, 1);
      check("bp_sel_hold", out_sel, 0);
      check("bp_en_low", en_acc, 0);
      @(posedge clk); #1;
    end
    m_ready_y = 1'b1;
    @(negedge clk);
    check("bp_lane0_valid", m_valid_y, 1);
    check("bp_lane0_sel", out_sel, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_lane1_valid", m_valid_y, 1);
    check("bp_lane1_sel", out_sel, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_next_clr", clr_acc, 1);
    check("bp_next_en", en_acc, 1);
    check("bp_next_valid", m_valid_y, 0);
    check("bp_next_xaddr", x_addr, P);

    // reset pulse at g=3, k=10
    found = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (clr_acc && x_addr == 6'(3 * P)) begin found = 1; break; end
    end
    check("rst_wait_g3", found, 1);
    repeat (10) @(posedge clk);
    #1;
    check("g3k10_xaddr", x_addr, 3 * P + 10);
    check("g3k10_faddr", f_addr, 10);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_en", en_acc, 0);
    check("mid_rst_xaddr", x_addr, 0);
    check("mid_rst_ready", s_ready_x, 0);
    @(posedge clk); #1;
    reset = 1'b0; s_valid_x = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("reload_ready", s_ready_x, 1);
      check("reload_wr", x_wr_en, 1);
      check("reload_xaddr", x_addr, i);
      @(posedge clk); #1;
    end
    s_valid_x = 1'b0;
    found = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (s_ready_x) begin found = 1; break; end
    end
    check("reload_done", found, 1);
    check("reload_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // random valid/ready over RV vectors
    in_hs = 0; out_hs = 0; found = 0;
    for (int c = 0; c < 60000; c++) begin
      s_valid_x = (in_hs < RV * N) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_ready_y = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (out_hs == RV * NY) begin found = 1; break; end
    end
    s_valid_x = 1'b0;
    check("rand_done", found, 1);
    check("rand_in_hs", in_hs, RV * N);
    check("rand_out_hs", out_hs, RV * NY);
    @(negedge clk);
    check("rand_end_load", s_ready_x, 1);
    check("rand_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
